// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the coefficient shadow bank:
//   - default sizing (NUM_TAPS / DW / AW)
//   - FSM state type (IDLE=0, LOAD=1, PEND=2, COMMIT=3)
//   - tap_lsb(): bit offset of tap k inside the flattened coefficient bus
// ---------------------------------------------------------------------------
package cfg_pkg;

    localparam int NUM_TAPS_DEF = 8;
    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PEND   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Tap k occupies bits [tap_lsb(k, dw) +: dw] of the flattened bus.
    function automatic int tap_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/wr_edge_det.sv
// ---------------------------------------------------------------------------
// wr_edge_det
// Registered rising-edge detector for a level strobe. A level held for many
// cycles yields a single one-cycle pulse on its first cycle high.
// The history register clears in reset, so a strobe already high when reset
// releases is reported as an edge on the first cycle out of reset.
// Ports:
//   clk    in  clock
//   rst_n  in  synchronous active-low reset
//   strobe in  level input
//   rise   out strobe & ~strobe_at_previous_edge
// ---------------------------------------------------------------------------
module wr_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise
);

    logic prev;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= strobe;
        end
    end

    assign rise = strobe & ~prev;

endmodule

// File: rtl/coef_shadow_bank.sv
// ---------------------------------------------------------------------------
// coef_shadow_bank
// FIR coefficient store with a shadow bank. Writes from the config stage
// land in the shadow bank; the whole shadow bank is copied to the active
// bank in a single cycle, and only once the FIR datapath reports idle, so
// the filter never sees a partially updated coefficient set.
// Ports:
//   iTck        in  clock
//   iTrst       in  synchronous active-low reset
//   iWrEn       in  write strobe (level; one write per rising edge)
//   iRegAddr    in  explicit write address
//   iData       in  write data
//   iRinc       in  1 = write at oPtr and post-increment it
//   iDesync     in  abort: shadow reverts to active, state back to IDLE
//   iCommitReq  in  request shadow -> active transfer (sampled in LOAD)
//   iFirIdle    in  FIR idle; commit waits in PEND until it is 1
//   oCoefFlat   out active coefficients, tap k at [k*DW +: DW]
//   oDirtyMask  out shadow taps written since last commit/abort
//   oPtr        out auto-increment pointer
//   oState      out FSM state
//   oCommitDone out one-cycle pulse alongside the active bank update
//   oCfgErr     out sticky: write attempted while in PEND/COMMIT
// ---------------------------------------------------------------------------
module coef_shadow_bank
    import cfg_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic                   iTck,
    input  logic                   iTrst,
    input  logic                   iWrEn,
    input  logic [AW-1:0]          iRegAddr,
    input  logic [DW-1:0]          iData,
    input  logic                   iRinc,
    input  logic                   iDesync,
    input  logic                   iCommitReq,
    input  logic                   iFirIdle,
    output logic [NUM_TAPS*DW-1:0] oCoefFlat,
    output logic [NUM_TAPS-1:0]    oDirtyMask,
    output logic [AW-1:0]          oPtr,
    output logic [1:0]             oState,
    output logic                   oCommitDone,
    output logic                   oCfgErr
);

    logic [DW-1:0]       active [NUM_TAPS];
    logic [DW-1:0]       shadow [NUM_TAPS];
    logic [NUM_TAPS-1:0] dirty;
    logic [AW-1:0]       ptr;
    logic                cfg_err;
    logic                commit_done;
    state_t              state;

    logic                wr_ev;
    logic [AW-1:0]       wr_addr;
    logic                wr_open;

    wr_edge_det u_wr_edge (
        .clk    (iTck),
        .rst_n  (iTrst),
        .strobe (iWrEn),
        .rise   (wr_ev)
    );

    assign wr_addr = iRinc ? ptr : iRegAddr;
    assign wr_open = (state == ST_IDLE) || (state == ST_LOAD);

    always_ff @(posedge iTck) begin
        if (!iTrst) begin
            // NOTE: both banks are small register arrays (not RAM) and must
            // read as zero after reset, so every entry is cleared here.
            for (int k = 0; k < NUM_TAPS; k++) begin
                active[k] <= '0;
                shadow[k] <= '0;
            end
            dirty       <= '0;
            ptr         <= '0;
            cfg_err     <= 1'b0;
            commit_done <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            commit_done <= 1'b0;
            if (iDesync) begin
                // Abort wins over any write or commit on the same edge.
                for (int k = 0; k < NUM_TAPS; k++) begin
                    shadow[k] <= active[k];
                end
                dirty   <= '0;
                ptr     <= '0;
                cfg_err <= 1'b0;
                state   <= ST_IDLE;
            end else begin
                if (wr_ev) begin
                    if (wr_open) begin
                        shadow[wr_addr] <= iData;
                        dirty[wr_addr]  <= 1'b1;
                        if (iRinc) begin
                            ptr <= ptr + AW'(1);
                        end
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end

                // NOTE: the default arm keeps the next-state decode fully
                // specified, so no path leaves state undefined.
                case (state)
                    ST_IDLE:   if (wr_ev)      state <= ST_LOAD;
                    ST_LOAD:   if (iCommitReq) state <= ST_PEND;
                    ST_PEND:   if (iFirIdle)   state <= ST_COMMIT;
                    ST_COMMIT: begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            active[k] <= shadow[k];
                        end
                        dirty       <= '0;
                        commit_done <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
        assign oCoefFlat[tap_lsb(k, DW) +: DW] = active[k];
    end

    assign oDirtyMask  = dirty;
    assign oPtr        = ptr;
    assign oState      = state;
    assign oCommitDone = commit_done;
    assign oCfgErr     = cfg_err;

endmodule

// File: doc/coef_shadow_bank.md
Name: coef_shadow_bank

Overview:
Downstream consumer of the JTAG configuration stage. It takes the decoded register write strobe, address and data byte (WrEn / regAddr / D7_D0, plus the RINC auto-increment and Desync controls) and stores the FIR coefficients. Writes go into a shadow bank. The shadow bank is committed atomically to the active bank only while the FIR datapath reports idle, so the filter never sees a half-updated coefficient set.

Parameters:
NUM_TAPS, 8, number of coefficient registers (power of two)
DW, 8, coefficient width in bits
AW, 3, address width; must equal log2(NUM_TAPS)

Ports:
iTck  in  1  clock; all state changes on rising edge
iTrst  in  1  reset, synchronous, active-low
iWrEn  in  1  write strobe from config stage; level, may be held several cycles
iRegAddr  in  AW  explicit write address
iData  in  DW  write data (D7_D0)
iRinc  in  1  1 = auto-increment addressing (use internal pointer, ignore iRegAddr)
iDesync  in  1  one-cycle abort pulse
iCommitReq  in  1  request to move shadow to active (level-sampled)
iFirIdle  in  1  FIR datapath idle; commit allowed only when 1
oCoefFlat  out  NUM_TAPS*DW  active coefficients; tap k at bits [k*DW +: DW]
oDirtyMask  out  NUM_TAPS  bit k = shadow tap k written since last commit/abort
oPtr  out  AW  auto-increment pointer
oState  out  2  FSM state
oCommitDone  out  1  one-cycle pulse when the active bank is updated
oCfgErr  out  1  sticky error flag

Behaviour:
- Reset (iTrst=0 at an edge): active bank, shadow bank, oDirtyMask, oPtr, oCommitDone and oCfgErr all go to 0. State goes to IDLE. Reset overrides every other input, including a commit in progress.
- Write detection:
  - A write event (wr_ev) occurs at an edge where iWrEn=1 and iWrEn was 0 at the previous edge.
  - A level held for N cycles produces exactly one write.
  - The edge-detector register resets to 0, so iWrEn already high when reset releases counts as an event on the first cycle out of reset.
- Write address: iRinc ? oPtr : iRegAddr.
- Write effect: on a wr_ev edge in IDLE or LOAD, the same edge updates shadow[addr] <= iData and sets oDirtyMask[addr]. If iRinc=1, oPtr also increments, wrapping from NUM_TAPS-1 to 0.
- oCoefFlat changes only in COMMIT.
- FSM, evaluated in priority order:
  - Any state, iDesync=1: shadow <= active, oDirtyMask <= 0, oPtr <= 0, oCfgErr <= 0, next state IDLE. A write or commit request on the same edge is dropped.
  - IDLE: on wr_ev, next state LOAD. iCommitReq is ignored (no oCommitDone pulse).
  - LOAD: writes are accepted. If iCommitReq=1, next state PEND. A write on the same edge is still applied before the transition.
  - PEND: wait while iFirIdle=0, with no timeout. When iFirIdle=1, next state COMMIT.
  - COMMIT (exactly one cycle): active <= shadow, oDirtyMask <= 0, oCommitDone=1 for this cycle only, next state IDLE.
- wr_ev in PEND or COMMIT: the write is rejected (shadow, mask and pointer untouched) and oCfgErr is set. oCfgErr clears only on iDesync or reset.
- Commit latency: from the LOAD edge that samples iCommitReq=1 with iFirIdle=1 held, oCoefFlat is updated 2 edges later.
- State encoding: IDLE=0, LOAD=1, PEND=2, COMMIT=3.

Decomposition:
- Shared package cfg_pkg holds: the state typedef/localparams, the NUM_TAPS/DW/AW defaults, and the tap-slice helper function (tap k to bit offset).
- One sub-module, wr_edge_det: registered rising-edge detector with synchronous active-low reset, reused for iWrEn. Instantiate it again if the config stage's other strobes need it.
- The register arrays and the FSM stay in coef_shadow_bank.

Test Plan:
1. Reset, then write addr 5 = 0xA5 with iRinc=0 -> oDirtyMask=8'h20, oState=LOAD, oCoefFlat stays 0. Then iCommitReq=1 with iFirIdle=1 -> 2 edges later tap5=0xA5, oCommitDone pulses once, mask=0, state IDLE.
2. iRinc=1 and 10 writes of values 1..10 (iWrEn high 3 cycles each), then commit -> taps 0..7 = {9,10,3,4,5,6,7,8}, oPtr=2, exactly 10 writes counted.
3. Write in LOAD, commit request with iFirIdle=0 for 20 cycles -> state holds PEND and oCoefFlat unchanged. Write during PEND -> rejected and oCfgErr=1. Raise iFirIdle -> commit proceeds with the pre-PEND data.
4. Commit tap3=0x11, then write tap3=0x22 and tap0=0x33, then iDesync -> shadow reverts to the active bank (tap3=0x11, tap0=0), mask=0, oPtr=0, oCfgErr=0, state IDLE. A subsequent commit request in IDLE produces no oCommitDone.
5. Assert iTrst=0 during PEND -> next edge: all outputs 0, state IDLE. After release, no oCommitDone pulse occurs.
6. iDesync and wr_ev on the same edge in LOAD -> the write is dropped and the mask stays 0.
